// File: rtl/mbtrain_sb_pkg.sv
// Shared types and constants for the MBTRAIN sideband arbiter.
// Configuration macro SB_ARB_RR_EN selects round-robin tie-breaking in the arbiter.
package mbtrain_sb_pkg;

  localparam int MSG_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    PULSE     = 2'd3
  } sb_arb_state_e;

  localparam logic OWN_TX = 1'b0;
  localparam logic OWN_RX = 1'b1;

  localparam logic [MSG_W-1:0] END_REQ  = 4'b0001;
  localparam logic [MSG_W-1:0] END_RESP = 4'b0010;

  // Ties go to TX unless rotating, in which case the side not granted last wins.
  function automatic logic pick_owner(input logic valid_tx, input logic valid_rx,
                                      input logic last_owner, input logic rotate);
    if (valid_tx && valid_rx) return rotate ? ~last_owner : OWN_TX;
    return valid_tx ? OWN_TX : OWN_RX;
  endfunction

endpackage

// File: rtl/sb_busy_edge_det.sv
// Registers the sideband serializer busy flag and produces one-cycle rise/fall strobes.
module sb_busy_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sb_busy,
  output logic o_rise,
  output logic o_fall
);

  logic r_busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy_d <= 1'b0;
    else        r_busy_d <= i_sb_busy;
  end

  assign o_rise = i_sb_busy && !r_busy_d;
  assign o_fall = r_busy_d && !i_sb_busy;

endmodule

// File: rtl/mbtrain_sb_arbiter.sv
// Arbitrates the sideband message port between the TX and RX sub-FSMs of an MBTRAIN substate.
// Define SB_ARB_RR_EN for round-robin tie-breaking; default build uses fixed TX priority.
//
//   state     | meaning
//   IDLE      | no transfer in flight; grant on enable, busy low and a pending request
//   LAUNCH    | o_sb_valid held with granted message until busy rises or timer expires
//   WAIT_DONE | serializer busy; waiting for its falling edge
//   PULSE     | one-cycle done pulse to the owner; requests ignored this cycle
module mbtrain_sb_arbiter
  import mbtrain_sb_pkg::*;
#(
  parameter int MSG_W        = mbtrain_sb_pkg::MSG_W,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid_tx,
  input  logic [MSG_W-1:0] i_msg_tx,
  input  logic             i_valid_rx,
  input  logic [MSG_W-1:0] i_msg_rx,
  input  logic             i_sb_busy,
  output logic [MSG_W-1:0] o_sb_msg,
  output logic             o_sb_valid,
  output logic             o_busy_negedge_detected,
  output logic             o_done_tx,
  output logic             o_done_rx,
  output logic             o_timeout
);

  localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

  sb_arb_state_e    r_state;
  sb_arb_state_e    w_state_nxt;
  logic [7:0]       r_timer;
  logic [MSG_W-1:0] r_msg;
  logic             r_owner;
  logic             r_timeout;
  logic             r_en_d;

  logic w_busy_rise;
  logic w_busy_fall;
  logic w_grant;
  logic w_win;
  logic w_tmo_hit;

  sb_busy_edge_det u_busy_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sb_busy (i_sb_busy),
    .o_rise    (w_busy_rise),
    .o_fall    (w_busy_fall)
  );

  assign w_grant = (r_state == IDLE) && i_en && !i_sb_busy && (i_valid_tx || i_valid_rx);

`ifdef SB_ARB_RR_EN
  assign w_win = pick_owner(i_valid_tx, i_valid_rx, r_owner, 1'b1);
`else
  assign w_win = pick_owner(i_valid_tx, i_valid_rx, OWN_TX, 1'b0);
`endif

  // Busy was low at grant, so a high busy in LAUNCH is always a fresh rise.
  assign w_tmo_hit = (r_state == LAUNCH) && !w_busy_rise && (r_timer == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_timer   <= 8'd0;
      r_msg     <= '0;
      r_owner   <= OWN_TX;
      r_timeout <= 1'b0;
      r_en_d    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= i_en;
      if (!i_en) begin
        r_timer <= 8'd0;
        r_msg   <= '0;
      end else if (w_grant) begin
        r_timer <= 8'd0;
        r_msg   <= (w_win == OWN_TX) ? i_msg_tx : i_msg_rx;
        r_owner <= w_win;
      end else if ((r_state == LAUNCH) && (r_timer != 8'hFF)) begin
        r_timer <= r_timer + 8'd1;
      end
      if (r_en_d && !i_en)          r_timeout <= 1'b0;
      else if (i_en && w_tmo_hit)   r_timeout <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:      if (w_grant) w_state_nxt = LAUNCH;
        LAUNCH: begin
          if (w_busy_rise)    w_state_nxt = WAIT_DONE;
          else if (w_tmo_hit) w_state_nxt = IDLE;
        end
        WAIT_DONE: if (w_busy_fall) w_state_nxt = PULSE;
        PULSE:     w_state_nxt = IDLE;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_sb_msg                = r_msg;
    o_sb_valid              = 1'b0;
    o_busy_negedge_detected = 1'b0;
    o_done_tx               = 1'b0;
    o_done_rx               = 1'b0;
    o_timeout               = r_timeout;
    case (r_state)
      LAUNCH: o_sb_valid = 1'b1;
      PULSE: begin
        o_busy_negedge_detected = 1'b1;
        o_done_tx               = (r_owner == OWN_TX);
        o_done_rx               = (r_owner == OWN_RX);
      end
      default: ;
    endcase
  end

endmodule
